// File: rtl/rename_dispatch_group.sv
// Rename group source-tag fixup feeding a 2-entry skid FIFO; optional DISPATCH_WAW_MASK_EN adds out_rat_we.
// Latency 1 cycle in->out; in_ready is state-only (count<2), never combinational on out_ready.
module rename_dispatch_group_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic [1:0]    count
);
  logic [DW-1:0] slot0, slot1;
  logic          push, pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  assign out_dat = slot0;

  // slot0 is always the head; an empty FIFO keeps showing the last group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_dat;
          else               slot1 <= in_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= in_dat;  // only reachable with count==1
        default: ;
      endcase
    end
  end
endmodule

module rename_dispatch_group #(
  parameter int WIDTH  = 4,
  parameter int ARCH_W = 5,
  parameter int PHY_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_lane_vld,
  input  logic [WIDTH*ARCH_W-1:0] in_rdst,
  input  logic [WIDTH*ARCH_W-1:0] in_src1,
  input  logic [WIDTH*ARCH_W-1:0] in_src2,
  input  logic [WIDTH*PHY_W-1:0]  in_phy,
  input  logic [WIDTH*PHY_W-1:0]  in_rsrc1,
  input  logic [WIDTH*PHY_W-1:0]  in_rsrc2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_lane_vld,
  output logic [WIDTH*ARCH_W-1:0] out_rdst,
  output logic [WIDTH*PHY_W-1:0]  out_phy,
  output logic [WIDTH*PHY_W-1:0]  out_src1,
  output logic [WIDTH*PHY_W-1:0]  out_src2,
  output logic [1:0]              out_count
`ifdef DISPATCH_WAW_MASK_EN
  ,
  output logic [WIDTH-1:0]        out_rat_we
`endif
);
`ifdef DISPATCH_WAW_MASK_EN
  localparam int DW = 2*WIDTH + WIDTH*ARCH_W + 3*WIDTH*PHY_W;
`else
  localparam int DW = WIDTH + WIDTH*ARCH_W + 3*WIDTH*PHY_W;
`endif

  logic [WIDTH*PHY_W-1:0] res1, res2;
  logic [DW-1:0]          push_dat, head_dat;

  // Ascending j: the youngest older writer overrides earlier matches
  always_comb begin
    res1 = in_rsrc1;
    res2 = in_rsrc2;
    for (int i = 1; i < WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        if (in_lane_vld[j] && (in_rdst[j*ARCH_W +: ARCH_W] != '0)) begin
          if (in_rdst[j*ARCH_W +: ARCH_W] == in_src1[i*ARCH_W +: ARCH_W])
            res1[i*PHY_W +: PHY_W] = in_phy[j*PHY_W +: PHY_W];
          if (in_rdst[j*ARCH_W +: ARCH_W] == in_src2[i*ARCH_W +: ARCH_W])
            res2[i*PHY_W +: PHY_W] = in_phy[j*PHY_W +: PHY_W];
        end
      end
    end
  end

`ifdef DISPATCH_WAW_MASK_EN
  logic [WIDTH-1:0] waw_we;

  // A destination overwritten by a younger valid lane must not update the RAT
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      waw_we[i] = in_lane_vld[i] && (in_rdst[i*ARCH_W +: ARCH_W] != '0);
      for (int k = i + 1; k < WIDTH; k++) begin
        if (in_lane_vld[k] && (in_rdst[k*ARCH_W +: ARCH_W] == in_rdst[i*ARCH_W +: ARCH_W]))
          waw_we[i] = 1'b0;
      end
    end
  end

  assign push_dat = {waw_we, in_lane_vld, in_rdst, in_phy, res1, res2};
  assign {out_rat_we, out_lane_vld, out_rdst, out_phy, out_src1, out_src2} = head_dat;
`else
  assign push_dat = {in_lane_vld, in_rdst, in_phy, res1, res2};
  assign {out_lane_vld, out_rdst, out_phy, out_src1, out_src2} = head_dat;
`endif

  rename_dispatch_group_fifo2 #(.DW(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (push_dat),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (head_dat),
    .count   (out_count)
  );
endmodule

// File: tb/tb_rename_dispatch_group.sv
// Directed bench for rename_dispatch_group at WIDTH=4, ARCH_W=5, PHY_W=6.
module tb_rename_dispatch_group;
  localparam int WIDTH  = 4;
  localparam int ARCH_W = 5;
  localparam int PHY_W  = 6;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_lane_vld = '0;
  logic [WIDTH*ARCH_W-1:0] in_rdst = '0, in_src1 = '0, in_src2 = '0;
  logic [WIDTH*PHY_W-1:0]  in_phy = '0, in_rsrc1 = '0, in_rsrc2 = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        out_lane_vld;
  logic [WIDTH*ARCH_W-1:0] out_rdst;
  logic [WIDTH*PHY_W-1:0]  out_phy, out_src1, out_src2;
  logic [1:0]              out_count;
`ifdef DISPATCH_WAW_MASK_EN
  logic [WIDTH-1:0]        out_rat_we;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_dispatch_group #(.WIDTH(WIDTH), .ARCH_W(ARCH_W), .PHY_W(PHY_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_vld  (in_lane_vld),
    .in_rdst      (in_rdst),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .in_phy       (in_phy),
    .in_rsrc1     (in_rsrc1),
    .in_rsrc2     (in_rsrc2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_vld (out_lane_vld),
    .out_rdst     (out_rdst),
    .out_phy      (out_phy),
    .out_src1     (out_src1),
    .out_src2     (out_src2),
    .out_count    (out_count)
`ifdef DISPATCH_WAW_MASK_EN
    ,
    .out_rat_we   (out_rat_we)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_group();
    in_lane_vld = '0;
    in_rdst = '0; in_src1 = '0; in_src2 = '0;
    in_phy = '0; in_rsrc1 = '0; in_rsrc2 = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input int rd, input int s1, input int s2,
                          input int phy, input int r1, input int r2);
    in_lane_vld[i] = v;
    in_rdst[i*ARCH_W +: ARCH_W] = ARCH_W'(rd);
    in_src1[i*ARCH_W +: ARCH_W] = ARCH_W'(s1);
    in_src2[i*ARCH_W +: ARCH_W] = ARCH_W'(s2);
    in_phy[i*PHY_W +: PHY_W]    = PHY_W'(phy);
    in_rsrc1[i*PHY_W +: PHY_W]  = PHY_W'(r1);
    in_rsrc2[i*PHY_W +: PHY_W]  = PHY_W'(r2);
  endtask

  // Group tagged only by lane0 phy, so FIFO order is visible on out_phy[5:0]
  task automatic tag_group(input int tag);
    clr_group();
    set_lane(0, 1'b1, 1, 2, 3, tag, 0, 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_count", 64'(out_count), 0);
    chk("rst_src1", 64'(out_src1), 0);
    chk("rst_phy", 64'(out_phy), 0);
    rst = 1'b0;
    tick();
    chk("idle_out_valid", 64'(out_valid), 0);
    chk("idle_in_ready", 64'(in_ready), 1);

    // Youngest older writer wins
    clr_group();
    set_lane(0, 1'b1, 3, 0, 0, 40, 5, 6);
    set_lane(1, 1'b1, 3, 0, 0, 41, 0, 0);
    set_lane(2, 1'b1, 8, 3, 4, 42, 7, 9);
    set_lane(3, 1'b1, 0, 2, 3, 43, 11, 12);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("raw_out_valid", 64'(out_valid), 1);
    chk("raw_lane2_src1", 64'(out_src1[2*PHY_W +: PHY_W]), 41);
    chk("raw_lane2_src2", 64'(out_src2[2*PHY_W +: PHY_W]), 9);
    chk("raw_lane0_src1", 64'(out_src1[0 +: PHY_W]), 5);
    chk("raw_lane3_src2", 64'(out_src2[3*PHY_W +: PHY_W]), 41);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("raw_popped_count", 64'(out_count), 0);

    // Same group with lane1 invalid: lane1 no longer a producer
    set_lane(1, 1'b0, 3, 0, 0, 41, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("inv_lane2_src1", 64'(out_src1[2*PHY_W +: PHY_W]), 40);
    chk("inv_lane1_vld", 64'(out_lane_vld), 4'b1101);
    chk("inv_lane1_phy", 64'(out_phy[1*PHY_W +: PHY_W]), 41);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // r0 is never a dependency
    clr_group();
    set_lane(0, 1'b1, 0, 0, 0, 50, 1, 2);
    set_lane(1, 1'b1, 6, 5, 0, 51, 9, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r0_lane1_src2", 64'(out_src2[1*PHY_W +: PHY_W]), 0);
    chk("r0_lane1_src1", 64'(out_src1[1*PHY_W +: PHY_W]), 9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_out_valid", 64'(out_valid), 0);
    chk("empty_hold_phy", 64'(out_phy[0 +: PHY_W]), 50);

    // Fill with A, B; head stays A while blocked
    tag_group(11); in_valid = 1'b1; tick();
    tag_group(12); tick();
    tag_group(14); tick();
    chk("full_count", 64'(out_count), 2);
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_head_a", 64'(out_phy[0 +: PHY_W]), 11);
    // Pop at full with D offered: D must not enter
    out_ready = 1'b1;
    tick();
    chk("pop_full_count", 64'(out_count), 1);
    chk("pop_full_head_b", 64'(out_phy[0 +: PHY_W]), 12);
    // Push C with pop at count 1
    tag_group(13);
    tick();
    chk("pushpop_count", 64'(out_count), 1);
    chk("pushpop_head_c", 64'(out_phy[0 +: PHY_W]), 13);
    in_valid = 1'b0;
    tick();
    chk("drain_count", 64'(out_count), 0);
    out_ready = 1'b0;

    // Flush at full with an incoming group
    tag_group(21); in_valid = 1'b1; tick();
    tag_group(22); tick();
    chk("pre_flush_count", 64'(out_count), 2);
    tag_group(23);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("flush_count", 64'(out_count), 0);
    chk("flush_in_ready", 64'(in_ready), 1);
    tick();
    chk("flush_not_stored", 64'(out_count), 0);

    // Asynchronous reset mid-operation
    tag_group(30); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("pre_arst_count", 64'(out_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(out_count), 0);
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_phy", 64'(out_phy), 0);
    rst = 1'b0;
    tick();

`ifdef DISPATCH_WAW_MASK_EN
    clr_group();
    set_lane(0, 1'b1, 9, 0, 0, 60, 0, 0);
    set_lane(1, 1'b1, 4, 0, 0, 61, 0, 0);
    set_lane(2, 1'b1, 0, 0, 0, 62, 0, 0);
    set_lane(3, 1'b1, 9, 0, 0, 63, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("waw_rat_we", 64'(out_rat_we), 4'b1010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_dispatch_group.md
Name: rename_dispatch_group

Overview:
- Parametrised N-wide successor to the 2-wide dispatch source-tag fixup.
- Takes a renamed group of WIDTH instructions:
  - architectural dst/src indices
  - newly allocated physical dst tags
  - RAT-lookup source tags
- Resolves intra-group RAW dependencies: each source takes the phys tag of the youngest older lane writing it.
- Buffers resolved groups in a 2-entry valid/ready skid FIFO ahead of the issue queues. Flush support included.

Parameters:
- WIDTH, 4, lanes per group (lane 0 oldest); legal 1..8
- ARCH_W, 5, architectural register index width; index 0 is hardwired zero, never a dependency
- PHY_W, 6, physical register tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard buffered and incoming groups
- in_valid  in  1  group present
- in_ready  out  1  group accepted this cycle when in_valid&in_ready
- in_lane_vld  in  WIDTH  per-lane valid (bit i = lane i)
- in_rdst  in  WIDTH*ARCH_W  arch dest per lane
- in_src1  in  WIDTH*ARCH_W  arch source 1 per lane
- in_src2  in  WIDTH*ARCH_W  arch source 2 per lane
- in_phy  in  WIDTH*PHY_W  allocated phys dest per lane
- in_rsrc1  in  WIDTH*PHY_W  RAT tag for src1
- in_rsrc2  in  WIDTH*PHY_W  RAT tag for src2
- out_valid  out  1  head group present
- out_ready  in  1  downstream accepts head
- out_lane_vld  out  WIDTH  head lane valids
- out_rdst  out  WIDTH*ARCH_W  head arch dests
- out_phy  out  WIDTH*PHY_W  head phys dests
- out_src1  out  WIDTH*PHY_W  resolved src1 tags
- out_src2  out  WIDTH*PHY_W  resolved src2 tags
- out_count  out  2  FIFO occupancy 0..2

Behaviour:
- Clocking and reset: one clock domain, rising edge.
  - rst is asynchronous, active-high.
  - On reset: count=0, out_valid=0, in_ready=1, all out_* data buses 0, out_count=0.
- Resolution (combinational, before FIFO write). For lane i, source s:
  - Candidates are lanes j<i with in_lane_vld[j]=1, in_rdst[j]==src_s[i], and in_rdst[j]!=0.
  - If any candidate exists, the resolved tag = in_phy[j] of the largest such j (youngest older writer).
  - Otherwise the resolved tag = in_rsrc_s[i].
  - Lane 0 always passes RAT tags through.
  - Invalid lanes are carried through with data unchanged. They never act as producers.
- FIFO: 2 entries, in-order.
  - Head drives out_*. A stored group is output unchanged until popped.
  - in_ready = (count<2), registered-equivalent: it depends on state only, never combinationally on out_ready.
  - out_valid = (count!=0).
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - push&pop simultaneous: count unchanged; FIFO order preserved.
  - Push into empty FIFO: out_valid rises the next cycle (1-cycle latency in to out).
  - Full (count=2): in_ready=0. A pop in that cycle does not allow a same-cycle push.
  - Empty: a pop is impossible; out_* data held at last value.
- Flush, sampled at the clock edge:
  - Next state count=0, out_valid=0, in_ready=1.
  - Any push or pop in the flush cycle is discarded.
  - Flush has priority over all other events.
- Reset mid-operation: all entries are dropped immediately, asynchronously.
- out_count mirrors count.

Optional Feature:
- Macro DISPATCH_WAW_MASK_EN.
- When defined:
  - Adds output out_rat_we (WIDTH).
  - Bit i = out_lane_vld[i] & (out_rdst[i]!=0) & no valid younger lane k>i in the same group with out_rdst[k]==out_rdst[i].
  - Computed at push and stored in the FIFO with the group.
  - Used to suppress RAT writes for intra-group-overwritten destinations.
- When undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_count=0, all out_* zero.
- WIDTH=4, lane0 rdst=3 phy=40, lane2 src1=3 rsrc1=7; lane1 rdst=3 phy=41 -> lane2 out_src1=41 (youngest older writer). Same group with lane1 invalid -> lane2 out_src1=40.
- Lane0 rdst=0 phy=50, lane1 src2=0 rsrc2=0 -> lane1 out_src2=0 (r0 never bypassed).
- Push groups A,B with out_ready=0 -> out_count=2, in_ready=0, head=A stable. Then pop -> head=B next cycle. Simultaneous push C and pop at count=1 -> count stays 1, order B then C.
- Flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, count=0, and the incoming group is not stored.
- DISPATCH_WAW_MASK_EN defined, lanes 0 and 3 rdst=9, all lanes valid -> out_rat_we[0]=0, out_rat_we[3]=1.
